ant_mem_arbiter: RTL and testbench
==================================

// Module: ant_mem_arbiter
// PURPOSE
//  Shares the single map RAM and pheromone RAM among N_ANTS ant agents using round-robin arbitration.
//  Each grant is a fixed 3-cycle window. For an exploring agent, the window fetches obstacle and pheromone
//  data for the 3 candidate neighbours. For a solved agent, the window does a saturating pheromone deposit
//  at its current position instead. Sits between the agent array and the two RAMs.
// PARAMETERS
//  N_ANTS        4        number of agents; must be >= 2
//  POS_ADDR      4        bits per coordinate; pos = {x[2*POS_ADDR-1:POS_ADDR], y[POS_ADDR-1:0]}
//  MAP_LEN       10       map side length; valid coordinate range 0..MAP_LEN-1
//  PH_DATA_SIZE  16       pheromone word width
//  PH_DEPOSIT    16'h0100 amount added per deposit
// PORTS
//  clk         in   1                 clock
//  rst         in   1                 reset, synchronous, active-low
//  bus_request in   N_ANTS            per-agent access request
//  solved      in   N_ANTS            per-agent solved flag (deposit mode)
//  pos_now     in   N_ANTS*2*POS_ADDR agent positions; agent i at [i*2*POS_ADDR +: 2*POS_ADDR]
//  step        in   N_ANTS*2          previous move per agent: 00 up, 01 right, 10 down, 11 left
//  bus_av      out  N_ANTS            one-hot grant; high for the first 2 window cycles only
//  data0_map   out  1                 obstacle-free flag, candidate slot 0/2 (broadcast)
//  data1_map   out  1                 obstacle-free flag, candidate slot 1
//  ph0, ph1    out  PH_DATA_SIZE      pheromone values for the same slots as data0_map/data1_map
//  mem_addr0   out  2*POS_ADDR        RAM read port 0 address (map and ph share the address)
//  mem_addr1   out  2*POS_ADDR        RAM read port 1 address
//  map_rd0/1   in   1                 map RAM read data; synchronous, 1-cycle latency
//  ph_rd0/1    in   PH_DATA_SIZE      ph RAM read data; 1-cycle latency
//  ph_we       out  1                 ph RAM write strobe
//  ph_waddr    out  2*POS_ADDR        ph write address
//  ph_wdata    out  PH_DATA_SIZE      ph write data
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, rr_ptr=0, holdoff mask cleared. A reset mid-window aborts the window; no ph_we is issued.
//  FSM: IDLE -> G0 -> G1 -> G2 -> IDLE.
//   - IDLE: pick the first requester at or after rr_ptr, cyclically. Latch its index, pos, step and solved.
//     Set rr_ptr = idx+1 (mod N_ANTS). If there are no requests, stay in IDLE.
//   - Holdoff: the agent granted last is masked for its first IDLE cycle, because its registered request is still high then.
//  Explore window (solved latched = 0). Candidates are taken in clockwise order from step:
//   - step 00 -> slots L,U,R; 01 -> U,R,D; 10 -> R,D,L; 11 -> D,L,U.
//   - Directions: up = y-1, down = y+1, right = x+1, left = x-1.
//   - G0: bus_av[idx]=1; mem_addr0=slot0, mem_addr1=slot1.
//   - G1: bus_av[idx]=1; data0_map/ph0 = slot0 result, data1_map/ph1 = slot1 result; mem_addr0=slot2.
//   - G2: bus_av=0; data0_map/ph0 = slot2 result; data1_map/ph1 = 0.
//  Bounds: a slot is invalid when its coordinate underflows (0-1) or is >= MAP_LEN.
//   - An invalid slot forces map=0 and ph=0 in its data cycle. Its address is driven to 0 (don't-care).
//   - The invalid flag is pipelined one cycle, aligned with RAM latency.
//  Deposit window (solved latched = 1):
//   - G0: bus_av[idx]=1; mem_addr0 = pos.
//   - G1: bus_av[idx]=1; sum = ph_rd0 + PH_DEPOSIT, computed PH_DATA_SIZE+1 wide and saturated to all-ones.
//   - G2: ph_we=1, ph_waddr=pos, ph_wdata=sum.
//   - data*/ph* outputs are 0 during a deposit window.
//  Outside G1/G2 all data outputs are 0. ph_we is high only in G2 of a deposit window.
//  Requests that arrive mid-window wait. A request that drops before IDLE is not granted.
//  Throughput: one window per 4 cycles (IDLE + G0..G2). RMW is serialised by the FSM, so there is no write/read hazard.
// STRUCTURE
//  Shared package ant_pkg: direction codes DIR_UP/RIGHT/DOWN/LEFT, POS_ADDR, MAP_LEN, PH_DATA_SIZE, and a pos packing function.
//  Sub-module ant_neighbor_gen (combinational):
//   - inputs: pos, step
//   - outputs: three slot addresses plus three valid bits
//  Round-robin selection and the FSM stay in this file.
// TESTING
//  1. Agent0 req, pos (3,4)=8'h34, step 10:
//     - expect addr0=8'h44, addr1=8'h35, then addr0=8'h24
//     - bus_av[0] high for exactly 2 cycles; data appear in G1 and G2
//  2. pos 8'h00, step 10:
//     - slot2 (left) invalid -> data0_map=0 and ph0=0 in G2, even with RAM at addr 0 = 1/16'h1234
//  3. Agents 1 and 3 request together with rr_ptr=0:
//     - grant order 1, 3, then 1 again only after 3
//     - no back-to-back regrant of the same agent
//  4. Solved agent2, pos 8'h99, RAM ph=16'h0200 -> ph_we in G2 with wdata=16'h0300.
//     Repeat with ph=16'hFFF0 -> wdata=16'hFFFF (saturated).
//  5. rst=0 asserted in G1 of a deposit window:
//     - next cycle all outputs 0 and ph_we never pulses
//     - after release, agent0 is granted first
//  6. All 4 agents request continuously for 64 cycles:
//     - each is granted exactly 4 times
//     - bus_av is always one-hot or zero

Source files
------------

// File: rtl/ant_pkg.sv
// ant_pkg: shared geometry constants, direction/state encodings and position packing for the ant memory arbiter
package ant_pkg;
  localparam int POS_ADDR = 4;
  localparam int MAP_LEN = 10;
  localparam int PH_DATA_SIZE = 16;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1, S_G2} arb_state_t;
  function automatic logic [2*POS_ADDR-1:0] pack_pos(input logic [POS_ADDR-1:0] x, input logic [POS_ADDR-1:0] y);
    return {x, y};
  endfunction
endpackage

// File: rtl/ant_neighbor_gen.sv
// ant_neighbor_gen: three clockwise candidate neighbour addresses and bounds flags from a position and previous step
module ant_neighbor_gen
  import ant_pkg::*;
(
  input  logic [2*POS_ADDR-1:0]      pos,
  input  logic [1:0]                 step,
  output logic [2:0][2*POS_ADDR-1:0] addr,
  output logic [2:0]                 valid
);
  localparam logic [POS_ADDR:0] ONE = (POS_ADDR+1)'(1);
  localparam logic [POS_ADDR:0] LIM = (POS_ADDR+1)'(MAP_LEN);
  logic [POS_ADDR:0] x;
  logic [POS_ADDR:0] y;
  logic [POS_ADDR:0] nx [4];
  logic [POS_ADDR:0] ny [4];
  logic [1:0] dir [3];
  // one extra bit per coordinate turns 0-1 into a huge value, so one compare catches underflow and overflow
  always_comb begin
    x = {1'b0, pos[2*POS_ADDR-1:POS_ADDR]};
    y = {1'b0, pos[POS_ADDR-1:0]};
    nx[DIR_UP] = x;
    ny[DIR_UP] = y - ONE;
    nx[DIR_RIGHT] = x + ONE;
    ny[DIR_RIGHT] = y;
    nx[DIR_DOWN] = x;
    ny[DIR_DOWN] = y + ONE;
    nx[DIR_LEFT] = x - ONE;
    ny[DIR_LEFT] = y;
    dir[0] = step - 2'd1;
    dir[1] = step;
    dir[2] = step + 2'd1;
    for (int s = 0; s < 3; s++) begin
      valid[s] = (nx[dir[s]] < LIM) && (ny[dir[s]] < LIM);
      addr[s] = valid[s] ? {nx[dir[s]][POS_ADDR-1:0], ny[dir[s]][POS_ADDR-1:0]} : '0;
    end
  end
endmodule

// File: rtl/ant_mem_arbiter.sv
// ant_mem_arbiter: round-robin 3-cycle windows sharing map/pheromone RAMs between ant agents
module ant_mem_arbiter
  import ant_pkg::*;
#(
  parameter int                      N_ANTS     = 4,
  parameter logic [PH_DATA_SIZE-1:0] PH_DEPOSIT = 16'h0100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_ANTS-1:0]              bus_request,
  input  logic [N_ANTS-1:0]              solved,
  input  logic [N_ANTS*2*POS_ADDR-1:0]   pos_now,
  input  logic [N_ANTS*2-1:0]            step,
  output logic [N_ANTS-1:0]              bus_av,
  output logic                           data0_map,
  output logic                           data1_map,
  output logic [PH_DATA_SIZE-1:0]        ph0,
  output logic [PH_DATA_SIZE-1:0]        ph1,
  output logic [2*POS_ADDR-1:0]          mem_addr0,
  output logic [2*POS_ADDR-1:0]          mem_addr1,
  input  logic                           map_rd0,
  input  logic                           map_rd1,
  input  logic [PH_DATA_SIZE-1:0]        ph_rd0,
  input  logic [PH_DATA_SIZE-1:0]        ph_rd1,
  output logic                           ph_we,
  output logic [2*POS_ADDR-1:0]          ph_waddr,
  output logic [PH_DATA_SIZE-1:0]        ph_wdata
);
  localparam int IW = $clog2(N_ANTS);
  localparam int PW = 2*POS_ADDR;
  arb_state_t state;
  arb_state_t state_nx;
  logic [IW-1:0] idx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand [N_ANTS];
  logic gnt_found;
  logic [N_ANTS-1:0] hold;
  logic [N_ANTS-1:0] req_m;
  logic [N_ANTS-1:0] idx_oh;
  logic [PW-1:0] pos_a [N_ANTS];
  logic [1:0] step_a [N_ANTS];
  logic [PW-1:0] pos_l;
  logic [1:0] step_l;
  logic solved_l;
  logic [2:0][PW-1:0] nb_addr;
  logic [2:0] nb_valid;
  logic v0_q;
  logic v1_q;
  logic [PH_DATA_SIZE:0] sum_w;
  logic [PH_DATA_SIZE-1:0] sum_q;
  logic explore;
  logic data_cyc;

  ant_neighbor_gen u_nb (
    .pos   (pos_l),
    .step  (step_l),
    .addr  (nb_addr),
    .valid (nb_valid)
  );

  assign idx_oh = N_ANTS'(1) << idx;
  assign explore = !solved_l;
  assign sum_w = {1'b0, ph_rd0} + {1'b0, PH_DEPOSIT};

  // round-robin pick: scan from rr_ptr downward in priority so the nearest requester wins; last grantee held off one cycle
  always_comb begin
    req_m = bus_request & ~hold;
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_ANTS; i++) begin
      pos_a[i] = pos_now[i*PW +: PW];
      step_a[i] = step[i*2 +: 2];
      cand[i] = IW'((int'(rr_ptr) + i) % N_ANTS);
    end
    for (int i = N_ANTS-1; i >= 0; i--)
      if (req_m[cand[i]]) begin
        gnt_found = 1'b1;
        gnt_idx = cand[i];
      end
  end

  // state register
  always_ff @(posedge clk)
    if (!rst) state <= S_IDLE;
    else state <= state_nx;

  // next state: fixed IDLE -> G0 -> G1 -> G2 walk once a requester is found
  always_comb
    state_nx = (state == S_IDLE) ? (gnt_found ? S_G0 : S_IDLE) :
               (state == S_G0) ? S_G1 :
               (state == S_G1) ? S_G2 : S_IDLE;

  // grant latch, pointer/holdoff update, bounds pipeline aligned with RAM latency, deposit sum capture
  always_ff @(posedge clk)
    if (!rst) begin
      idx <= '0;
      rr_ptr <= '0;
      hold <= '0;
      pos_l <= '0;
      step_l <= '0;
      solved_l <= 1'b0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      sum_q <= '0;
    end else begin
      if (state == S_IDLE && gnt_found) begin
        idx <= gnt_idx;
        rr_ptr <= IW'((int'(gnt_idx) + 1) % N_ANTS);
        pos_l <= pos_a[gnt_idx];
        step_l <= step_a[gnt_idx];
        solved_l <= solved[gnt_idx];
      end
      hold <= (state == S_G2) ? idx_oh : '0;
      v0_q <= (state == S_G0 && explore) ? nb_valid[0] : (state == S_G1 && explore) ? nb_valid[2] : 1'b0;
      v1_q <= (state == S_G0 && explore) ? nb_valid[1] : 1'b0;
      if (state == S_G1) sum_q <= sum_w[PH_DATA_SIZE] ? '1 : sum_w[PH_DATA_SIZE-1:0];
    end

  // outputs: addresses in G0/G1, read data forwarded in the following cycle, write-back only in deposit G2
  always_comb begin
    data_cyc = (state == S_G1 || state == S_G2) && explore;
    bus_av = (state == S_G0 || state == S_G1) ? idx_oh : '0;
    mem_addr0 = (state == S_G0) ? (solved_l ? pos_l : nb_addr[0]) :
                (state == S_G1 && explore) ? nb_addr[2] : '0;
    mem_addr1 = (state == S_G0 && explore) ? nb_addr[1] : '0;
    data0_map = (data_cyc && v0_q) ? map_rd0 : 1'b0;
    ph0 = (data_cyc && v0_q) ? ph_rd0 : '0;
    data1_map = (state == S_G1 && explore && v1_q) ? map_rd1 : 1'b0;
    ph1 = (state == S_G1 && explore && v1_q) ? ph_rd1 : '0;
    ph_we = (state == S_G2) && solved_l;
    ph_waddr = ph_we ? pos_l : '0;
    ph_wdata = ph_we ? sum_q : '0;
  end
endmodule

// File: tb/tb_ant_mem_arbiter.sv
// tb_ant_mem_arbiter: directed vector table plus hand sequences for arbitration, bounds, deposit and reset corners
module tb_ant_mem_arbiter;
  import ant_pkg::*;
  logic clk;
  logic rst;
  logic [3:0] bus_request;
  logic [3:0] solved;
  logic [31:0] pos_now;
  logic [7:0] step;
  logic [3:0] bus_av;
  logic data0_map;
  logic data1_map;
  logic [15:0] ph0;
  logic [15:0] ph1;
  logic [7:0] mem_addr0;
  logic [7:0] mem_addr1;
  logic map_rd0;
  logic map_rd1;
  logic [15:0] ph_rd0;
  logic [15:0] ph_rd1;
  logic ph_we;
  logic [7:0] ph_waddr;
  logic [15:0] ph_wdata;
  logic map_mem [256];
  logic [15:0] ph_mem [256];
  int n_vec;
  int n_bad;

  typedef struct {
    int agent;
    logic [7:0] pos;
    logic [1:0] st;
    logic [7:0] a0, a1, a2;
    logic m0, m1, m2;
    logic [15:0] p0, p1, p2;
  } vec_t;
  vec_t vt [6];

  ant_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus_request (bus_request),
    .solved      (solved),
    .pos_now     (pos_now),
    .step        (step),
    .bus_av      (bus_av),
    .data0_map   (data0_map),
    .data1_map   (data1_map),
    .ph0         (ph0),
    .ph1         (ph1),
    .mem_addr0   (mem_addr0),
    .mem_addr1   (mem_addr1),
    .map_rd0     (map_rd0),
    .map_rd1     (map_rd1),
    .ph_rd0      (ph_rd0),
    .ph_rd1      (ph_rd1),
    .ph_we       (ph_we),
    .ph_waddr    (ph_waddr),
    .ph_wdata    (ph_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    map_rd0 <= map_mem[mem_addr0];
    map_rd1 <= map_mem[mem_addr1];
    ph_rd0 <= ph_mem[mem_addr0];
    ph_rd1 <= ph_mem[mem_addr1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_agent(input int ag, input logic sv, input logic [7:0] p, input logic [1:0] s);
    bus_request = 4'b0001 << ag;
    solved = {3'b000, sv} << ag;
    pos_now = '0;
    pos_now[ag*8 +: 8] = p;
    step = '0;
    step[ag*2 +: 2] = s;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int t;
    t = 0;
    while (bus_av == 4'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("grant_wait", {31'b0, bus_av != 4'b0}, 32'd1);
    g = bus_av;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] ord [4];
    logic [3:0] prev;
    int n;
    int bad_oh;
    int cnt [4];
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    bus_request = '0;
    solved = '0;
    pos_now = '0;
    step = '0;
    for (int a = 0; a < 256; a++) begin
      map_mem[a] = a[0];
      ph_mem[a] = {a[7:0], ~a[7:0]};
    end
    map_mem[0] = 1'b1;
    ph_mem[0] = 16'h1234;
    vt[0] = '{0, 8'h34, 2'd2, 8'h44, 8'h35, 8'h24, 1'b0, 1'b1, 1'b0, 16'h44BB, 16'h35CA, 16'h24DB};
    vt[1] = '{0, 8'h00, 2'd2, 8'h10, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 16'h10EF, 16'h01FE, 16'h0000};
    vt[2] = '{1, 8'h55, 2'd0, 8'h45, 8'h54, 8'h65, 1'b1, 1'b0, 1'b1, 16'h45BA, 16'h54AB, 16'h659A};
    vt[3] = '{3, 8'h90, 2'd1, 8'h00, 8'h00, 8'h91, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h916E};
    vt[4] = '{2, 8'h09, 2'd3, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h08F7};
    vt[5] = '{1, 8'h27, 2'd1, 8'h26, 8'h37, 8'h28, 1'b0, 1'b1, 1'b0, 16'h26D9, 16'h37C8, 16'h28D7};
    repeat (3) @(negedge clk);
    chk("rst_bus_av", {28'b0, bus_av}, 32'h0);
    chk("rst_ph_we", {31'b0, ph_we}, 32'h0);
    chk("rst_addr0", {24'b0, mem_addr0}, 32'h0);
    chk("rst_addr1", {24'b0, mem_addr1}, 32'h0);
    chk("rst_data0", {31'b0, data0_map}, 32'h0);
    chk("rst_ph0", {16'b0, ph0}, 32'h0);
    chk("rst_wdata", {16'b0, ph_wdata}, 32'h0);
    rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_agent(vt[v].agent, 1'b0, vt[v].pos, vt[v].st);
      wait_grant(g);
      chk("g0_bus_av", {28'b0, g}, 32'(4'b0001 << vt[v].agent));
      chk("g0_addr0", {24'b0, mem_addr0}, {24'b0, vt[v].a0});
      chk("g0_addr1", {24'b0, mem_addr1}, {24'b0, vt[v].a1});
      chk("g0_data0", {31'b0, data0_map}, 32'h0);
      bus_request = '0;
      @(negedge clk);
      chk("g1_bus_av", {28'b0, bus_av}, 32'(4'b0001 << vt[v].agent));
      chk("g1_addr0", {24'b0, mem_addr0}, {24'b0, vt[v].a2});
      chk("g1_map0", {31'b0, data0_map}, {31'b0, vt[v].m0});
      chk("g1_ph0", {16'b0, ph0}, {16'b0, vt[v].p0});
      chk("g1_map1", {31'b0, data1_map}, {31'b0, vt[v].m1});
      chk("g1_ph1", {16'b0, ph1}, {16'b0, vt[v].p1});
      @(negedge clk);
      chk("g2_bus_av", {28'b0, bus_av}, 32'h0);
      chk("g2_map0", {31'b0, data0_map}, {31'b0, vt[v].m2});
      chk("g2_ph0", {16'b0, ph0}, {16'b0, vt[v].p2});
      chk("g2_map1", {31'b0, data1_map}, 32'h0);
      chk("g2_ph1", {16'b0, ph1}, 32'h0);
      chk("g2_ph_we", {31'b0, ph_we}, 32'h0);
    end

    for (int d = 0; d < 2; d++) begin
      ph_mem[8'h99] = (d == 0) ? 16'h0200 : 16'hFFF0;
      set_agent(2, 1'b1, pack_pos(4'd9, 4'd9), 2'd0);
      wait_grant(g);
      chk("dep_g0_bus", {28'b0, g}, 32'h4);
      chk("dep_g0_addr", {24'b0, mem_addr0}, 32'h99);
      bus_request = '0;
      @(negedge clk);
      chk("dep_g1_bus", {28'b0, bus_av}, 32'h4);
      chk("dep_g1_ph0", {16'b0, ph0}, 32'h0);
      chk("dep_g1_we", {31'b0, ph_we}, 32'h0);
      @(negedge clk);
      chk("dep_g2_we", {31'b0, ph_we}, 32'h1);
      chk("dep_g2_waddr", {24'b0, ph_waddr}, 32'h99);
      chk("dep_g2_wdata", {16'b0, ph_wdata}, (d == 0) ? 32'h0300 : 32'hFFFF);
      chk("dep_g2_bus", {28'b0, bus_av}, 32'h0);
      chk("dep_g2_data0", {31'b0, data0_map}, 32'h0);
      @(negedge clk);
      chk("dep_idle_we", {31'b0, ph_we}, 32'h0);
    end

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_request = 4'b1010;
    solved = '0;
    pos_now = 32'h55555555;
    step = '0;
    ord = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      chk("rr_order", {28'b0, g}, {28'b0, ord[k]});
      n = 0;
      while (bus_av != 4'b0 && n < 10) begin
        n++;
        @(negedge clk);
      end
      chk("bus_av_len", n, 32'd2);
    end

    set_agent(0, 1'b1, 8'h12, 2'd0);
    wait_grant(g);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_bus", {28'b0, bus_av}, 32'h0);
    chk("mid_rst_we", {31'b0, ph_we}, 32'h0);
    chk("mid_rst_addr0", {24'b0, mem_addr0}, 32'h0);
    chk("mid_rst_wdata", {16'b0, ph_wdata}, 32'h0);
    @(negedge clk);
    chk("mid_rst_we2", {31'b0, ph_we}, 32'h0);
    bus_request = 4'b1111;
    solved = '0;
    rst = 1'b1;
    wait_grant(g);
    chk("post_rst_first", {28'b0, g}, 32'h1);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prev = '0;
    bad_oh = 0;
    cnt = '{0, 0, 0, 0};
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if ((bus_av & (bus_av - 4'd1)) != 4'b0) bad_oh++;
      if (bus_av != 4'b0 && prev == 4'b0)
        for (int a = 0; a < 4; a++)
          if (bus_av[a]) cnt[a]++;
      prev = bus_av;
    end
    for (int a = 0; a < 4; a++) chk("fair_count", cnt[a], 32'd4);
    chk("onehot_viol", bad_oh, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
